// File: rtl/loop_nest_gen_if.sv
// loop_nest_gen_if: tuple stream between the loop nest generator and its consumer
//   o_valid  generator -> consumer  tuple is valid
//   i_ready  consumer -> generator  tuple accepted
//   o_idx    generator -> consumer  index per level
//   o_iter   generator -> consumer  0-based iteration per level
//   o_last   generator -> consumer  level is on its final iteration
interface loop_nest_gen_if #(parameter int NDEPTH = 3, parameter int IDXDW = 11, parameter int CNTDW = 8);
   logic                           o_valid;
   logic                           i_ready;
   logic [NDEPTH-1:0][IDXDW-1:0]   o_idx;
   logic [NDEPTH-1:0][CNTDW-1:0]   o_iter;
   logic [NDEPTH-1:0]              o_last;
   modport master (output o_valid, o_idx, o_iter, o_last, input i_ready);
   modport slave  (input o_valid, o_idx, o_iter, o_last, output i_ready);
endinterface

// File: rtl/loop_nest_gen.sv
// loop_nest_gen: N-deep nested loop index generator (level 0 innermost) on a valid/ready stream
//   i_clk, i_rst_n    clock, asynchronous active-low reset
//   i_start, i_abort  start a run (idle only) / terminate a run without completion
//   i_base, i_stride  per-level first index and increment, latched at start
//   i_count           per-level trip count, latched at start (0 behaves as 1)
//   o_busy, o_done    not idle / one-cycle pulse after the final tuple is accepted
//   st                tuple stream (master side)
module loop_nest_gen #(parameter int NDEPTH = 3, parameter int IDXDW = 11, parameter int CNTDW = 8) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_start,
   input  logic                         i_abort,
   input  logic [NDEPTH-1:0][IDXDW-1:0] i_base,
   input  logic [NDEPTH-1:0][IDXDW-1:0] i_stride,
   input  logic [NDEPTH-1:0][CNTDW-1:0] i_count,
   output logic                         o_busy,
   output logic                         o_done,
   loop_nest_gen_if.master              st
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, nextState;
   logic [NDEPTH-1:0][IDXDW-1:0] baseQ, strideQ, idxQ;
   logic [NDEPTH-1:0][CNTDW-1:0] countQ, iterQ;
   logic [NDEPTH-1:0] lastV, step;
   logic hs, adv;

   assign hs  = st.o_valid & st.i_ready;
   // abort wins over a same-cycle handshake: the tuple is not consumed
   assign adv = hs & ~i_abort;

   for (genvar g = 0; g < NDEPTH; g++) begin : gLvl
      assign lastV[g] = iterQ[g] == countQ[g] - 1'b1;
      // odometer carry: a level steps only when every faster level wraps
      if (g == 0) begin : gStep0
         assign step[g] = 1'b1;
      end else begin : gStepN
         assign step[g] = step[g-1] & lastV[g-1];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) state <= IDLE;
      else          state <= nextState;

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    nextState = i_start ? RUN : IDLE;
         RUN:     nextState = i_abort ? IDLE : (hs & (&lastV)) ? DONE : RUN;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         baseQ   <= '0;
         strideQ <= '0;
         idxQ    <= '0;
         iterQ   <= '0;
         for (int l = 0; l < NDEPTH; l++) countQ[l] <= CNTDW'(1);
      end else if (state == IDLE && i_start) begin
         baseQ   <= i_base;
         strideQ <= i_stride;
         idxQ    <= i_base;
         iterQ   <= '0;
         for (int l = 0; l < NDEPTH; l++) countQ[l] <= (i_count[l] == '0) ? CNTDW'(1) : i_count[l];
      end else if (adv) begin
         for (int l = 0; l < NDEPTH; l++)
            if (step[l]) begin
               iterQ[l] <= lastV[l] ? '0 : iterQ[l] + 1'b1;
               idxQ[l]  <= lastV[l] ? baseQ[l] : idxQ[l] + strideQ[l];
            end
      end

   assign st.o_valid = state == RUN;
   assign st.o_idx   = idxQ;
   assign st.o_iter  = iterQ;
   assign st.o_last  = lastV;
   assign o_busy     = state != IDLE;
   assign o_done     = state == DONE;
endmodule
